mig_wr_drain: RTL

Write-side drain engine for the MIG DDR user interface. It pops WIDTH-bit words from the controller's write-data FIFO and packs APP_DATA_WIDTH/WIDTH of them into one UI data beat. It then issues a MIG write command (app_cmd = 3'b000) at an auto-incrementing address. It is the consumer of the FIFO's pop/data_out/empty side, sitting between the FIFO and the MIG app_* ports.

---
 rtl/mig_wr_drain.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mig_wr_drain.sv
// mig_wr_drain: write-side drain engine for the MIG DDR user interface.
// Pops WIDTH-bit words from a first-word-fall-through FIFO and packs
// APP_DATA_WIDTH/WIDTH of them into one UI data beat, first word in the LSBs.
// Each beat is then written with a single-beat MIG write command at an
// auto-incrementing address.
// Optional feature macro: MIG_WR_DRAIN_FLUSH_EN -- lets 'flush' write out a
// partial beat, zero-filling and byte-masking the missing words.
module mig_wr_drain #(
    parameter int WIDTH          = 16,
    parameter int APP_DATA_WIDTH = 128,
    parameter int ADDR_WIDTH     = 28,
    parameter int ADDR_STEP      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
    input  logic                        flush,
    output logic                        busy,
    input  logic [WIDTH-1:0]            fifo_data,
    input  logic                        fifo_empty,
    output logic                        fifo_pop,
    input  logic                        init_calib_complete,
    output logic                        app_en,
    output logic [2:0]                  app_cmd,
    output logic [ADDR_WIDTH-1:0]       app_addr,
    input  logic                        app_rdy,
    output logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
    output logic                        app_wdf_wren,
    output logic                        app_wdf_end,
    output logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                        app_wdf_rdy
);

    localparam int BEATS  = APP_DATA_WIDTH / WIDTH;
    localparam int CNT_W  = $clog2(BEATS + 1);
    localparam int MASK_W = APP_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATHER = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             cmd_done_r;
    logic             dat_done_r;
    logic             pop_s;
    logic             flush_take_s;
    logic             cmd_hs_s;
    logic             dat_hs_s;
    logic             cmd_fin_s;
    logic             dat_fin_s;

    // Only single-beat write bursts are ever issued.
    assign app_cmd     = 3'b000;
    assign app_wdf_end = app_wdf_wren;
    assign fifo_pop    = pop_s;

    assign cmd_hs_s  = app_en & app_rdy;
    assign dat_hs_s  = app_wdf_wren & app_wdf_rdy;
    assign cmd_fin_s = cmd_done_r | cmd_hs_s;
    assign dat_fin_s = dat_done_r | dat_hs_s;

`ifdef MIG_WR_DRAIN_FLUSH_EN
    // Byte mask covering every byte at or above the first missing word.
    function automatic logic [MASK_W-1:0] tail_mask(input logic [CNT_W-1:0] words);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (i * 8 >= int'(words) * WIDTH) m[i] = 1'b1;
            else                              m[i] = 1'b0;
        end
        return m;
    endfunction

    // A flush is honoured only when the beat is genuinely partial.
    always_comb begin
        flush_take_s = 1'b0;
        if (state_r == ST_GATHER && flush && cnt_r != CNT_W'(0) && cnt_r < CNT_W'(BEATS))
            flush_take_s = 1'b1;
        else
            flush_take_s = 1'b0;
    end
`else
    logic unused_flush_s;
    assign flush_take_s   = 1'b0;
    assign unused_flush_s = flush;
`endif

    // Pop the FIFO head whenever a word is available and the beat has room;
    // never during reset so no word is consumed that the engine then drops.
    always_comb begin
        pop_s = 1'b0;
        if (!rst && state_r == ST_GATHER && !fifo_empty && cnt_r < CNT_W'(BEATS) && !flush_take_s)
            pop_s = 1'b1;
        else
            pop_s = 1'b0;
    end

    // Drain FSM: gather words, then hold command and data until both are accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            cmd_done_r   <= 1'b0;
            dat_done_r   <= 1'b0;
            busy         <= 1'b0;
            app_en       <= 1'b0;
            app_wdf_wren <= 1'b0;
            app_addr     <= '0;
            app_wdf_data <= '0;
            app_wdf_mask <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && init_calib_complete) begin
                        app_addr     <= base_addr;
                        cnt_r        <= '0;
                        app_wdf_data <= '0;
                        app_wdf_mask <= '0;
                        busy         <= 1'b1;
                        state_r      <= ST_GATHER;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GATHER: begin
                    if (flush_take_s) begin
                        // Unfilled words are already zero: the pack is cleared per beat.
`ifdef MIG_WR_DRAIN_FLUSH_EN
                        app_wdf_mask <= tail_mask(cnt_r);
`endif
                        app_en       <= 1'b1;
                        app_wdf_wren <= 1'b1;
                        state_r      <= ST_WRITE;
                    end else if (pop_s) begin
                        app_wdf_data[int'(cnt_r) * WIDTH +: WIDTH] <= fifo_data;
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == CNT_W'(BEATS - 1)) begin
                            app_en       <= 1'b1;
                            app_wdf_wren <= 1'b1;
                            state_r      <= ST_WRITE;
                        end else begin
                            state_r <= ST_GATHER;
                        end
                    end else begin
                        state_r <= ST_GATHER;
                    end
                end
                ST_WRITE: begin
                    // Command and data may be accepted in either order.
                    if (cmd_hs_s) begin
                        app_en     <= 1'b0;
                        cmd_done_r <= 1'b1;
                    end
                    if (dat_hs_s) begin
                        app_wdf_wren <= 1'b0;
                        dat_done_r   <= 1'b1;
                    end
                    if (cmd_fin_s && dat_fin_s) begin
                        app_addr     <= app_addr + ADDR_WIDTH'(ADDR_STEP);
                        cnt_r        <= '0;
                        cmd_done_r   <= 1'b0;
                        dat_done_r   <= 1'b0;
                        app_wdf_data <= '0;
                        app_wdf_mask <= '0;
                        state_r      <= ST_GATHER;
                    end else begin
                        state_r <= ST_WRITE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cnt_r        <= '0;
                    cmd_done_r   <= 1'b0;
                    dat_done_r   <= 1'b0;
                    busy         <= 1'b0;
                    app_en       <= 1'b0;
                    app_wdf_wren <= 1'b0;
                end
            endcase
        end
    end

endmodule
